// File: rtl/stl_mask_builder.sv
// stl_mask_builder: rebuilds a DW-bit mask from a stream of 1-based bit
// positions. Each accepted index sets one bit; the beat flagged in_last closes
// the frame. The finished mask and its population count are held until
// downstream accepts them.
//
// Optional feature macro: STL_MASK_BUILDER_ERR_EN (adds the err port).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   index beat offered
//   in_ready   out  beat can be accepted (out_ready pass-through in HOLD)
//   in_idx     in   CW+1 bit 1-based position, 0 = null beat
//   in_last    in   beat closes the frame
//   out_valid  out  completed mask is held
//   out_ready  in   downstream accepts the mask
//   out_mask   out  DW bit accumulated mask
//   out_cnt    out  CW+1 bit count of set bits in out_mask
//   err        out  [0] duplicate index, [1] out-of-range index (macro only)
module stl_mask_builder #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW:0]   in_idx,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_mask,
    output logic [CW:0]   out_cnt
`ifdef STL_MASK_BUILDER_ERR_EN
    ,
    output logic [1:0]    err
`endif
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state;
    logic [DW-1:0] dec;
    logic          in_range;
    logic          oor;
    logic          dup;
    logic          accept;

    // Decode of the offered index; nulls and out-of-range indices decode to 0.
    always_comb begin
        dec      = '0;
        in_range = (in_idx != '0) && (in_idx <= (CW+1)'(DW));
        oor      = in_idx > (CW+1)'(DW);
        if (in_range) begin
            dec = DW'(1) << (in_idx - (CW+1)'(1));
        end
        dup = in_range && ((out_mask & dec) != '0);
    end

    // Ready is forced low while reset is asserted, then follows the state.
    assign in_ready = rst_n && ((state == ACCUM) || out_ready);
    assign accept   = in_valid && in_ready;

    // Frame FSM with the mask, count and flags as registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            out_mask  <= '0;
            out_cnt   <= '0;
`ifdef STL_MASK_BUILDER_ERR_EN
            err       <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        out_mask <= out_mask | dec;
                        if (in_range && !dup) begin
                            out_cnt <= out_cnt + (CW+1)'(1);
                        end
`ifdef STL_MASK_BUILDER_ERR_EN
                        err <= err | {oor, dup};
`endif
                        if (in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Release; a beat accepted in the same cycle starts the next frame.
                    if (out_ready) begin
                        if (accept) begin
                            out_mask  <= dec;
                            out_cnt   <= (CW+1)'(in_range);
`ifdef STL_MASK_BUILDER_ERR_EN
                            err       <= {oor, 1'b0};
`endif
                            state     <= in_last ? HOLD : ACCUM;
                            out_valid <= in_last;
                        end else begin
                            out_mask  <= '0;
                            out_cnt   <= '0;
`ifdef STL_MASK_BUILDER_ERR_EN
                            err       <= '0;
`endif
                            state     <= ACCUM;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stl_mask_builder.sv
// Testbench for stl_mask_builder: directed frames checked by literal
// expectations plus a set-based frame model compared on every cycle.
module tb_stl_mask_builder;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW:0]   in_idx;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_mask;
    logic [CW:0]   out_cnt;
`ifdef STL_MASK_BUILDER_ERR_EN
    logic [1:0]    err;
`endif

    int tests = 0;
    int fails = 0;
    bit started = 0;

    stl_mask_builder #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_cnt   (out_cnt)
`ifdef STL_MASK_BUILDER_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the open frame is a set of positions plus sticky flags; a closed
    // frame becomes the held result until a release.
    bit            acc_set [1:DW];
    bit            acc_dup, acc_oor;
    bit            h_valid;
    logic [DW-1:0] h_mask;
    int            h_cnt;
    logic [1:0]    h_err;

    task automatic model_clear_acc();
        for (int p = 1; p <= DW; p++) acc_set[p] = 0;
        acc_dup = 0;
        acc_oor = 0;
    endtask

    initial begin
        model_clear_acc();
        h_valid = 0;
        h_mask  = '0;
        h_cnt   = 0;
        h_err   = '0;
    end

    always @(negedge clk) begin
        bit exp_rdy;
        bit acc;
        int ix;
        exp_rdy = rst_n && (!h_valid || out_ready);
        if (started) begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(h_valid));
            if (h_valid) begin
                chk("out_mask", 32'(out_mask), 32'(h_mask));
                chk("out_cnt", 32'(out_cnt), 32'(h_cnt));
`ifdef STL_MASK_BUILDER_ERR_EN
                chk("err", 32'(err), 32'(h_err));
`endif
            end
        end
        if (!rst_n) begin
            model_clear_acc();
            h_valid = 0;
        end else begin
            acc = in_valid && exp_rdy;
            if (h_valid && out_ready) h_valid = 0;
            if (acc) begin
                ix = int'(in_idx);
                if (ix >= 1 && ix <= DW) begin
                    if (acc_set[ix]) acc_dup = 1;
                    acc_set[ix] = 1;
                end else if (ix > DW) begin
                    acc_oor = 1;
                end
                if (in_last) begin
                    h_mask = '0;
                    h_cnt  = 0;
                    for (int p = 1; p <= DW; p++) begin
                        if (acc_set[p]) begin
                            h_mask[p-1] = 1'b1;
                            h_cnt++;
                        end
                    end
                    h_err   = {acc_oor, acc_dup};
                    h_valid = 1;
                    model_clear_acc();
                end
            end
        end
    end

    // Offer one beat and wait until it is accepted; returns at posedge+1.
    task automatic beat(input int idx, input bit last);
        int budget;
        bit got;
        in_valid = 1'b1;
        in_idx   = (CW+1)'(idx);
        in_last  = last;
        budget   = 0;
        got      = 0;
        while (!got && budget < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_idx   = '0;
        if (!got) chk("beat_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        started = 1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_mask", 32'(out_mask), 32'(0));
        chk("rst_out_cnt", 32'(out_cnt), 32'(0));
`ifdef STL_MASK_BUILDER_ERR_EN
        chk("rst_err", 32'(err), 32'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame {3, 1, 6 last}
        beat(3, 0);
        beat(1, 0);
        beat(6, 1);
        @(negedge clk);
        chk("f1_valid", 32'(out_valid), 32'(1));
        chk("f1_mask", 32'(out_mask), 32'h25);
        chk("f1_cnt", 32'(out_cnt), 32'(3));
        chk("f1_stall_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("f1_released", 32'(out_valid), 32'(0));
        out_ready = 1'b0;

        // Empty frame
        beat(0, 1);
        chk("null_valid", 32'(out_valid), 32'(1));
        chk("null_mask", 32'(out_mask), 32'(0));
        chk("null_cnt", 32'(out_cnt), 32'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Duplicate and out-of-range beats
        beat(2, 0);
        beat(2, 0);
        beat(9, 1);
        chk("dup_mask", 32'(out_mask), 32'h02);
        chk("dup_cnt", 32'(out_cnt), 32'(1));
`ifdef STL_MASK_BUILDER_ERR_EN
        chk("dup_err", 32'(err), 32'(3));
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Stall with {8 last} held and {4 last} waiting
        beat(8, 1);
        in_valid = 1'b1;
        in_idx   = (CW+1)'(4);
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready", 32'(in_ready), 32'(0));
            chk("stall_mask", 32'(out_mask), 32'h80);
            chk("stall_valid", 32'(out_valid), 32'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pass_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_idx   = '0;
        chk("b2b_valid", 32'(out_valid), 32'(1));
        chk("b2b_mask", 32'(out_mask), 32'h08);
        chk("b2b_cnt", 32'(out_cnt), 32'(1));
        @(posedge clk);
        #1;

        // One-beat frames 1..8 on consecutive cycles
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_idx   = (CW+1)'(i);
            in_last  = 1'b1;
            @(posedge clk);
            #1;
            chk("seq_valid", 32'(out_valid), 32'(1));
            chk("seq_mask", 32'(out_mask), 32'(1) << (i - 1));
            chk("seq_cnt", 32'(out_cnt), 32'(1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_idx   = '0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset mid-frame discards {5, 7}
        beat(5, 0);
        beat(7, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_mask", 32'(out_mask), 32'(0));
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        rst_n = 1'b1;
        beat(1, 1);
        @(negedge clk);
        chk("post_rst_mask", 32'(out_mask), 32'h01);
        chk("post_rst_cnt", 32'(out_cnt), 32'(1));
        chk("post_rst_valid", 32'(out_valid), 32'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stl_mask_builder.md
# stl_mask_builder

Sequential index-to-mask decoder: the inverse of the trailing-zero/first-one encoder in the common library. It accepts a stream of 1-based bit positions over a valid/ready handshake and ORs each into an accumulating DW-bit mask. On the beat flagged `in_last` it presents the finished mask and its population count downstream. It sits behind arbiters and grant queues that serialise one-hot or multi-hot vectors as position indices, and it rebuilds those vectors on the far side.

## Interface
- `DW`, 8: mask width in bits, at least 2, need not be a power of two.
- `CW`, 3: index width; must equal `$clog2(DW)`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  an index beat is offered.
- `in_ready`  out  1  the block can accept a beat.
- `in_idx`  in  CW+1  1-based bit position; 0 is a null beat that sets no bit.
- `in_last`  in  1  the beat closes the current frame.
- `out_valid`  out  1  a completed mask is held.
- `out_ready`  in  1  downstream accepts the mask.
- `out_mask`  out  DW  the accumulated mask.
- `out_cnt`  out  CW+1  number of distinct bits set in `out_mask`.
- `err`  out  2  present only with `STL_MASK_BUILDER_ERR_EN`. Bit 0 flags a duplicate, bit 1 flags an out-of-range index.

## Operation
- Two states, `ACCUM` and `HOLD`. Reset enters `ACCUM`.
- Accept rule: a beat is accepted when `in_valid & in_ready`.
- **In `ACCUM`:**
  - `in_ready` = 1.
  - On an accepted beat with 1 ≤ `in_idx` ≤ DW, set mask bit `in_idx-1`.
  - `cnt` increments only if that bit was previously clear.
  - A null beat (`in_idx` = 0) changes nothing.
  - An index greater than DW is ignored.
  - An accepted beat with `in_last` = 1 moves the block to `HOLD`. The bit update from that beat is included.
- **In `HOLD`:**
  - `out_valid` = 1. `out_mask` and `out_cnt` are stable.
  - `in_ready` = `out_ready`, a pass-through for back-to-back frames.
  - **If `out_ready` = 1:**
    - The frame is released.
    - The mask and count are reloaded with the decode of the input beat accepted that same cycle, if any; otherwise they clear to 0.
    - If that beat also has `in_last` = 1, stay in `HOLD`; otherwise go to `ACCUM`.
  - **If `out_ready` = 0:** stall. No input is accepted.
- Arithmetic:
  - `cnt` saturates naturally, because at most DW distinct bits can be set and DW fits in CW+1 bits.
  - The decode is `1 << (in_idx-1)`, computed at width DW. Indices in the range DW+1 … 2^(CW+1)-1 are out of range.
- An empty frame (a single null beat with `in_last`) yields `out_mask` = 0 and `out_cnt` = 0. This matches the encoder's "no bit found" output of `pos_from1` = 0.

## Timing
- Reset values: `in_ready` = 0 during the reset cycle and 1 afterwards; `out_valid` = 0; `out_mask` = 0; `out_cnt` = 0; `err` = 0; state is `ACCUM`.
- Latency: if the last beat is accepted in cycle N, `out_valid` is high in cycle N+1.
- Throughput: one index per cycle sustained, including across frame boundaries when `out_ready` is held high. A one-beat frame completes every cycle.
- All outputs are registered; there is no combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` to `in_ready`, and only in `HOLD`.
- Reset asserted mid-frame discards the partial mask and any held output on the next edge.
- `out_valid` must not drop, and `out_mask` must not change, until a handshake completes.

## Configuration
- `STL_MASK_BUILDER_ERR_EN`:
  - **Defined:** the `err` port exists. Bit 0 sets on an accepted beat whose bit is already set in the current frame. Bit 1 sets on an accepted index greater than DW. Both bits are sticky for the frame, are presented with `out_valid`, and clear when the frame is released or on reset.
  - **Undefined:** the port and its logic are absent. Duplicate and out-of-range beats are still silently ignored, as described under Operation.

## Test plan
- Reset, then frame {3, 1, 6 last} with DW=8 → `out_valid` one cycle after the last beat; `out_mask` = 8'b0010_0101; `out_cnt` = 3.
- Single null beat with last → `out_mask` = 0, `out_cnt` = 0, `out_valid` = 1 for one handshake.
- Frame {2, 2, 9 last} with the macro defined → `out_mask` = 8'b0000_0010, `out_cnt` = 1, `err` = 2'b11. Without the macro, the same mask and count.
- `out_ready` low for 5 cycles while holding {8 last} → `in_ready` = 0 throughout, mask 8'h80 stable. Then raise `out_ready` with beat {4 last} presented → next output is 8'h08 with no bubble.
- Back-to-back one-beat frames 1…8 with `out_ready` = 1 → eight outputs on consecutive cycles, 8'h01 through 8'h80, each with `out_cnt` = 1.
- Assert `rst_n` = 0 after beats {5, 7} of an unfinished frame, then send {1 last} → `out_mask` = 8'h01, `out_cnt` = 1.
